// File: rtl/i2s_rcv.sv
// rtl/i2s_rcv.sv - I2S slave receiver: oversampled deserializer for 24-bit stereo slots, upper bits out with a per-frame vld pulse.
// Optional ws framing check enabled by defining FRAME_CHK_EN.
module i2s_rcv #(
    parameter int SLOT_W = 24,
    parameter int OUT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             I2S_sclk,
    input  logic             I2S_ws,
    input  logic             I2S_data,
    output logic [OUT_W-1:0] lft_chnnl,
    output logic [OUT_W-1:0] rght_chnnl,
    output logic             vld,
    output logic             frm_err
);

    typedef enum logic [1:0] {SYNC = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} state_t;

    localparam logic [4:0] LAST = 5'(SLOT_W - 1);

    state_t            state, nxt_state;
    logic [2:0]        sclk_sr;
    logic [1:0]        ws_sr;
    logic [1:0]        data_sr;
    logic [4:0]        bit_cnt;
    logic [SLOT_W-1:0] shft_l;
    logic [SLOT_W-1:0] shft_r;
    logic              ws_prev;
    logic              done_q;

    logic rise, ws_s, data_s, last, ws_fall, ws_bad;
    logic shift_l, shift_r, cnt_clr, cnt_inc, done, err;

    // ws and data share the sclk sync depth so they stay aligned with the detected edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr <= '0;
            ws_sr   <= '0;
            data_sr <= '0;
        end else begin
            sclk_sr <= {sclk_sr[1:0], I2S_sclk};
            ws_sr   <= {ws_sr[0], I2S_ws};
            data_sr <= {data_sr[0], I2S_data};
        end
    end

    assign rise    = sclk_sr[1] & ~sclk_sr[2];
    assign ws_s    = ws_sr[1];
    assign data_s  = data_sr[1];
    assign last    = (bit_cnt == LAST);
    assign ws_fall = ~ws_s & ws_prev;

`ifdef FRAME_CHK_EN
    logic ws_exp;
    assign ws_exp = (state == LEFT) ? last : ~last;
    assign ws_bad = (state != SYNC) && (ws_s != ws_exp);
`else
    assign ws_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SYNC;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        if (rise) begin
            case (state)
                SYNC:  if (ws_fall) nxt_state = LEFT;
                LEFT: begin
                    if (ws_bad)    nxt_state = ws_fall ? LEFT : SYNC;
                    else if (last) nxt_state = RIGHT;
                end
                RIGHT: begin
                    if (ws_bad)    nxt_state = ws_fall ? LEFT : SYNC;
                    else if (last) nxt_state = LEFT;
                end
                default: nxt_state = SYNC;
            endcase
        end
    end

    always_comb begin
        shift_l = 1'b0;
        shift_r = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        if (rise) begin
            case (state)
                SYNC: cnt_clr = ws_fall;
                LEFT, RIGHT: begin
                    if (ws_bad) begin
                        err     = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        shift_l = (state == LEFT);
                        shift_r = (state == RIGHT);
                        cnt_clr = last;
                        cnt_inc = ~last;
                        done    = last && (state == RIGHT);
                    end
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shft_l     <= '0;
            shft_r     <= '0;
            ws_prev    <= 1'b0;
            done_q     <= 1'b0;
            lft_chnnl  <= '0;
            rght_chnnl <= '0;
            vld        <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            if (rise)    ws_prev <= ws_s;
            if (cnt_clr) bit_cnt <= '0;
            else if (cnt_inc) bit_cnt <= bit_cnt + 5'd1;
            if (shift_l) shft_l <= {shft_l[SLOT_W-2:0], data_s};
            if (shift_r) shft_r <= {shft_r[SLOT_W-2:0], data_s};
            done_q  <= done;
            frm_err <= err;
            vld     <= done_q;
            if (done_q) begin
                lft_chnnl  <= shft_l[SLOT_W-1 -: OUT_W];
                rght_chnnl <= shft_r[SLOT_W-1 -: OUT_W];
            end
        end
    end

endmodule
